jogo_sequencia_param: RTL and testbench

Parametrised successor of the 4-switch sequence-memory game datapath/control pair. The block checks player moves on `N_CHAVES` one-hot switches against an internal sequence of `DEPTH` entries. It runs in either fixed-length mode or progressive-round mode, where round k requires k+1 correct moves. An optional inactivity timeout is compiled in by macro. It sits directly under the board top level, between the switch/LED pins and the 7-segment debug encoders.

---
 rtl/jogo_sequencia_param.sv | 208 ++++++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: sequence-memory game that checks one-hot switch moves against a bouncing ROM pattern (fixed or progressive rounds).
// Latency: a move sampled at edge k is judged after edge k+3 and the game is back in ESPERA after k+4; outputs are Moore-decoded.
// Backpressure: none; a new move is only accepted once the switches return to zero. Optional inactivity timeout: define JOGO_TIMEOUT_EN.
module jogo_sequencia_param #(
  parameter  int N_CHAVES       = 4,
  parameter  int DEPTH          = 16,
  parameter  int PROGRESSIVO    = 1,
  parameter  int LIMITE_TIMEOUT = 5000,
  localparam int CW             = $clog2(DEPTH)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                iniciar_i,
  input  logic [N_CHAVES-1:0] chaves_i,
  output logic                acertou_o,
  output logic                errou_o,
  output logic                pronto_o,
  output logic                timeout_o,
  output logic [N_CHAVES-1:0] leds_o,
  output logic [3:0]          db_estado_o,
  output logic [CW-1:0]       db_contagem_o,
  output logic [CW-1:0]       db_rodada_o,
  output logic [N_CHAVES-1:0] db_memoria_o,
  output logic [N_CHAVES-1:0] db_jogada_o,
  output logic                db_igual_o,
  output logic                db_tem_jogada_o
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMA     = 4'h6,
    PROX_RODADA = 4'h7,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam logic [CW-1:0] ULTIMO     = CW'(DEPTH - 1);
  localparam logic [CW-1:0] RODADA_INI = (PROGRESSIVO != 0) ? '0 : ULTIMO;

  // Position bounces 0..N-1..1 with period 2N-2; entry is the one-hot of that position.
  function automatic logic [N_CHAVES-1:0] padrao(input int i);
    int m;
    m = i % (2 * N_CHAVES - 2);
    if (m >= N_CHAVES) m = 2 * N_CHAVES - 2 - m;
    return N_CHAVES'(1) << m;
  endfunction

  estado_t             estado_q, estado_d;
  logic [N_CHAVES-1:0] chaves_q, chaves_prev_q;
  logic [CW-1:0]       contagem_q, contagem_d;
  logic [CW-1:0]       rodada_q, rodada_d;
  logic [N_CHAVES-1:0] jogada_q, jogada_d;
  logic [N_CHAVES-1:0] rom [2**CW];
  logic [N_CHAVES-1:0] memoria;
  logic                tem_jogada;
  logic                igual;

`ifdef JOGO_TIMEOUT_EN
  localparam int            TW        = (LIMITE_TIMEOUT > 1) ? $clog2(LIMITE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(LIMITE_TIMEOUT - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          expirou;
  assign expirou = (timer_q == TIMER_MAX);
`endif

  // ROM is padded to a power of two so every index value is defined; only 0..DEPTH-1 is reachable.
  for (genvar g = 0; g < 2**CW; g++) begin : g_rom
    assign rom[g] = padrao(g);
  end

  assign memoria    = rom[contagem_q];
  assign tem_jogada = (|chaves_q) & ~(|chaves_prev_q);
  assign igual      = (jogada_q == memoria);

  // State register
  always_ff @(posedge clock_i) begin
    if (!reset_i) estado_q <= INICIAL;
    else          estado_q <= estado_d;
  end

  // Next-state decision
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (iniciar_i) estado_d = PREPARA;
      PREPARA:     estado_d = ESPERA;
      ESPERA: begin
        if (tem_jogada) estado_d = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
        else if (expirou) estado_d = FIM_TIMEOUT;
`endif
      end
      REGISTRA:    estado_d = COMPARA;
      COMPARA: begin
        if (!igual)                                         estado_d = FIM_ERRO;
        else if (contagem_q == rodada_q && rodada_q == ULTIMO) estado_d = FIM_ACERTO;
        else if (contagem_q == rodada_q)                    estado_d = PROX_RODADA;
        else                                                estado_d = PROXIMA;
      end
      PROXIMA:     estado_d = ESPERA;
      PROX_RODADA: estado_d = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar_i) estado_d = PREPARA;
      default:     estado_d = INICIAL;
    endcase
  end

  // Game-result outputs decoded from the registered state only
  always_comb begin
    pronto_o  = 1'b0;
    acertou_o = 1'b0;
    errou_o   = 1'b0;
    timeout_o = 1'b0;
    case (estado_q)
      FIM_ACERTO: begin
        pronto_o  = 1'b1;
        acertou_o = 1'b1;
      end
      FIM_ERRO: begin
        pronto_o = 1'b1;
        errou_o  = 1'b1;
      end
`ifdef JOGO_TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto_o  = 1'b1;
        errou_o   = 1'b1;
        timeout_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Counter / latched-move updates driven by the current state
  always_comb begin
    contagem_d = contagem_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
`ifdef JOGO_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (estado_q)
      PREPARA: begin
        contagem_d = '0;
        rodada_d   = RODADA_INI;
        jogada_d   = '0;
`ifdef JOGO_TIMEOUT_EN
        timer_d    = '0;
`endif
      end
`ifdef JOGO_TIMEOUT_EN
      ESPERA: if (!expirou) timer_d = timer_q + TW'(1);
`endif
      REGISTRA: jogada_d = chaves_q;
      PROXIMA: begin
        contagem_d = contagem_q + CW'(1);
`ifdef JOGO_TIMEOUT_EN
        timer_d    = '0;
`endif
      end
      PROX_RODADA: begin
        rodada_d   = rodada_q + CW'(1);
        contagem_d = '0;
`ifdef JOGO_TIMEOUT_EN
        timer_d    = '0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers, including the switch sampler used for edge detection
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      chaves_q      <= '0;
      chaves_prev_q <= '0;
      contagem_q    <= '0;
      rodada_q      <= '0;
      jogada_q      <= '0;
`ifdef JOGO_TIMEOUT_EN
      timer_q       <= '0;
`endif
    end else begin
      chaves_q      <= chaves_i;
      chaves_prev_q <= chaves_q;
      contagem_q    <= contagem_d;
      rodada_q      <= rodada_d;
      jogada_q      <= jogada_d;
`ifdef JOGO_TIMEOUT_EN
      timer_q       <= timer_d;
`endif
    end
  end

  assign leds_o          = chaves_q;
  assign db_estado_o     = estado_q;
  assign db_contagem_o   = contagem_q;
  assign db_rodada_o     = rodada_q;
  assign db_memoria_o    = memoria;
  assign db_jogada_o     = jogada_q;
  assign db_igual_o      = igual;
  assign db_tem_jogada_o = tem_jogada;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: fixed-length instance (DEPTH=7) and progressive instance (DEPTH=3).
// A game-level model predicts every output each cycle; directed literal checks pin key moments.
// The inactivity-timeout scenario follows whichever build of JOGO_TIMEOUT_EN is compiled.
module tb_jogo_sequencia_param;

  localparam int LIM = 20;
`ifdef JOGO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // model stages
  localparam int S_OFF = 0, S_PREP = 1, S_WAIT = 2, S_REG = 3, S_CMP = 4, S_ADV = 5, S_RND = 6, S_END = 7;
  // model results
  localparam int R_WIN = 1, R_ERR = 2, R_TMO = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ini [2];
  logic [3:0] ch  [2];

  logic       acertou [2], errou [2], pronto [2], tmo [2], igual [2], tj [2];
  logic [3:0] leds [2], estado [2], mem [2], jog [2];
  logic [2:0] cont0, rod0;
  logic [1:0] cont1, rod1;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  int pat [16];
  int cr [2], cp [2], stg [2], idx [2], rnd [2], mv [2], res [2], w [2];

  always #5 clk = ~clk;

  jogo_sequencia_param #(.N_CHAVES(4), .DEPTH(7), .PROGRESSIVO(0), .LIMITE_TIMEOUT(LIM)) u_fixo (
    .clock_i(clk), .reset_i(rst_n), .iniciar_i(ini[0]), .chaves_i(ch[0]),
    .acertou_o(acertou[0]), .errou_o(errou[0]), .pronto_o(pronto[0]), .timeout_o(tmo[0]),
    .leds_o(leds[0]), .db_estado_o(estado[0]), .db_contagem_o(cont0), .db_rodada_o(rod0),
    .db_memoria_o(mem[0]), .db_jogada_o(jog[0]), .db_igual_o(igual[0]), .db_tem_jogada_o(tj[0])
  );

  jogo_sequencia_param #(.N_CHAVES(4), .DEPTH(3), .PROGRESSIVO(1), .LIMITE_TIMEOUT(LIM)) u_prog (
    .clock_i(clk), .reset_i(rst_n), .iniciar_i(ini[1]), .chaves_i(ch[1]),
    .acertou_o(acertou[1]), .errou_o(errou[1]), .pronto_o(pronto[1]), .timeout_o(tmo[1]),
    .leds_o(leds[1]), .db_estado_o(estado[1]), .db_contagem_o(cont1), .db_rodada_o(rod1),
    .db_memoria_o(mem[1]), .db_jogada_o(jog[1]), .db_igual_o(igual[1]), .db_tem_jogada_o(tj[1])
  );

  function automatic int depth_of(input int d);
    return (d == 0) ? 7 : 3;
  endfunction

  function automatic bit prog_of(input int d);
    return d == 1;
  endfunction

  function automatic int contv(input int d);
    return (d == 0) ? int'(cont0) : int'(cont1);
  endfunction

  function automatic int rodv(input int d);
    return (d == 0) ? int'(rod0) : int'(rod1);
  endfunction

  function automatic int code_of(input int d);
    case (stg[d])
      S_OFF:  return 0;
      S_PREP: return 1;
      S_WAIT: return 2;
      S_REG:  return 4;
      S_CMP:  return 5;
      S_ADV:  return 6;
      S_RND:  return 7;
      default: return (res[d] == R_WIN) ? 10 : (res[d] == R_ERR) ? 14 : 13;
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Game-level model: switch history, progress through the sequence, and the verdict of each move
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        cr[d] <= 0; cp[d] <= 0; stg[d] <= S_OFF; idx[d] <= 0;
        rnd[d] <= 0; mv[d] <= 0; res[d] <= 0; w[d] <= 0;
      end else begin
        cp[d] <= cr[d];
        cr[d] <= int'(ch[d]);
        case (stg[d])
          S_OFF, S_END: if (ini[d]) stg[d] <= S_PREP;
          S_PREP: begin
            idx[d] <= 0;
            rnd[d] <= prog_of(d) ? 0 : depth_of(d) - 1;
            mv[d]  <= 0;
            w[d]   <= 0;
            stg[d] <= S_WAIT;
          end
          S_WAIT: begin
            if (cr[d] != 0 && cp[d] == 0) stg[d] <= S_REG;
            else begin
              w[d] <= w[d] + 1;
              if (TO_EN && w[d] + 1 == LIM) begin
                res[d] <= R_TMO;
                stg[d] <= S_END;
              end
            end
          end
          S_REG: begin
            mv[d]  <= cr[d];
            stg[d] <= S_CMP;
          end
          S_CMP: begin
            if (mv[d] != pat[idx[d]]) begin
              res[d] <= R_ERR; stg[d] <= S_END;
            end else if (idx[d] == rnd[d] && rnd[d] == depth_of(d) - 1) begin
              res[d] <= R_WIN; stg[d] <= S_END;
            end else if (idx[d] == rnd[d]) stg[d] <= S_RND;
            else stg[d] <= S_ADV;
          end
          S_ADV: begin
            idx[d] <= idx[d] + 1; w[d] <= 0; stg[d] <= S_WAIT;
          end
          S_RND: begin
            rnd[d] <= rnd[d] + 1; idx[d] <= 0; w[d] <= 0; stg[d] <= S_WAIT;
          end
          default: stg[d] <= S_OFF;
        endcase
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("estado",     d, int'(estado[d]),  code_of(d));
        chk("pronto",     d, int'(pronto[d]),  int'(stg[d] == S_END));
        chk("acertou",    d, int'(acertou[d]), int'(stg[d] == S_END && res[d] == R_WIN));
        chk("errou",      d, int'(errou[d]),   int'(stg[d] == S_END && res[d] >= R_ERR));
        chk("timeout",    d, int'(tmo[d]),     int'(stg[d] == S_END && res[d] == R_TMO));
        chk("leds",       d, int'(leds[d]),    cr[d]);
        chk("tem_jogada", d, int'(tj[d]),      int'(cr[d] != 0 && cp[d] == 0));
        chk("contagem",   d, contv(d),         idx[d]);
        chk("rodada",     d, rodv(d),          rnd[d]);
        chk("memoria",    d, int'(mem[d]),     pat[idx[d]]);
        chk("jogada",     d, int'(jog[d]),     mv[d]);
        chk("igual",      d, int'(igual[d]),   int'(mv[d] == pat[idx[d]]));
      end
    end
  end

  task automatic jogar(input int d, input logic [3:0] v, input int hold);
    ch[d] = v;
    repeat (hold) @(negedge clk);
    ch[d] = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int pos, dir;
    int ref_pat [8];
    ref_pat = '{1, 2, 4, 8, 4, 2, 1, 2};
    pos = 0;
    dir = 1;
    for (int i = 0; i < 16; i++) begin
      pat[i] = 1 << pos;
      if (pos == 3) dir = -1;
      if (pos == 0) dir = 1;
      pos = pos + dir;
    end
    for (int i = 0; i < 8; i++) chk("rom_model", 0, pat[i], ref_pat[i]);

    rst_n = 1'b0;
    ini[0] = 1'b0; ini[1] = 1'b0;
    ch[0] = 4'b0000; ch[1] = 4'b0000;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_estado",  0, int'(estado[0]), 0);
    chk("rst_memoria", 0, int'(mem[0]), 1);
    chk("rst_estado",  1, int'(estado[1]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fixed mode: start, six correct moves, wrong seventh move
    ini[0] = 1'b1;
    @(negedge clk);
    chk("start_prepara", 0, int'(estado[0]), 1);
    @(negedge clk);
    chk("start_espera", 0, int'(estado[0]), 2);
    repeat (3) @(negedge clk);
    ini[0] = 1'b0;
    jogar(0, 4'b0001, 10); jogar(0, 4'b0010, 10); jogar(0, 4'b0100, 10);
    jogar(0, 4'b1000, 10); jogar(0, 4'b0100, 10); jogar(0, 4'b0010, 10);
    ch[0] = 4'b0100;
    repeat (3) @(negedge clk);
    chk("err_k2_errou",  0, int'(errou[0]), 0);
    chk("err_k2_estado", 0, int'(estado[0]), 5);
    @(negedge clk);
    chk("err_errou",    0, int'(errou[0]), 1);
    chk("err_pronto",   0, int'(pronto[0]), 1);
    chk("err_estado",   0, int'(estado[0]), 14);
    chk("err_contagem", 0, contv(0), 6);
    ch[0] = 4'b0000;
    repeat (10) @(negedge clk);

    // fixed mode: restart without reset and win
    ini[0] = 1'b1; @(negedge clk); ini[0] = 1'b0; @(negedge clk);
    jogar(0, 4'b0001, 10); jogar(0, 4'b0010, 10); jogar(0, 4'b0100, 10);
    jogar(0, 4'b1000, 10); jogar(0, 4'b0100, 10); jogar(0, 4'b0010, 10);
    ch[0] = 4'b0001;
    repeat (4) @(negedge clk);
    chk("win_acertou", 0, int'(acertou[0]), 1);
    chk("win_pronto",  0, int'(pronto[0]), 1);
    chk("win_estado",  0, int'(estado[0]), 10);
    ch[0] = 4'b0000;
    repeat (10) @(negedge clk);

    // progressive mode: held switch counts once; rounds of 1, 2 and 3 moves
    ini[1] = 1'b1; @(negedge clk); ini[1] = 1'b0; @(negedge clk);
    chk("prog_rodada0", 1, rodv(1), 0);
    ch[1] = 4'b0001;
    repeat (30) @(negedge clk);
    chk("hold_estado",   1, int'(estado[1]), 2);
    chk("hold_rodada",   1, rodv(1), 1);
    chk("hold_contagem", 1, contv(1), 0);
    ch[1] = 4'b0000;
    repeat (10) @(negedge clk);
    jogar(1, 4'b0001, 10); jogar(1, 4'b0010, 10);
    chk("prog_rodada2", 1, rodv(1), 2);
    jogar(1, 4'b0001, 10); jogar(1, 4'b0010, 10);
    ch[1] = 4'b0100;
    repeat (4) @(negedge clk);
    chk("prog_acertou", 1, int'(acertou[1]), 1);
    chk("prog_estado",  1, int'(estado[1]), 10);
    ch[1] = 4'b0000;
    repeat (10) @(negedge clk);

    // multi-bit move at index 0 is a loss
    ini[1] = 1'b1; @(negedge clk); ini[1] = 1'b0; @(negedge clk);
    ch[1] = 4'b0011;
    repeat (4) @(negedge clk);
    chk("multi_errou",  1, int'(errou[1]), 1);
    chk("multi_estado", 1, int'(estado[1]), 14);
    ch[1] = 4'b0000;
    repeat (10) @(negedge clk);

    // reset mid-game with iniciar held high
    ini[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_estado",  0, int'(estado[0]), 0);
    chk("mid_rst_pronto",  0, int'(pronto[0]), 0);
    chk("mid_rst_acertou", 0, int'(acertou[0]), 0);
    chk("mid_rst_errou",   0, int'(errou[0]), 0);
    chk("mid_rst_memoria", 0, int'(mem[0]), 1);
    chk("mid_rst_estado",  1, int'(estado[1]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_prepara", 0, int'(estado[0]), 1);
    ini[0] = 1'b0;
    repeat (2) @(negedge clk);

    // inactivity: 20 ESPERA cycles, then timeout (or keep waiting when not built)
    ini[1] = 1'b1; @(negedge clk); ini[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_espera", 1, int'(estado[1]), 2);
    @(negedge clk);
`ifdef JOGO_TIMEOUT_EN
    chk("to_estado",  1, int'(estado[1]), 13);
    chk("to_timeout", 1, int'(tmo[1]), 1);
    chk("to_errou",   1, int'(errou[1]), 1);
    chk("to_pronto",  1, int'(pronto[1]), 1);
`else
    chk("no_to_estado",  1, int'(estado[1]), 2);
    chk("no_to_timeout", 1, int'(tmo[1]), 0);
`endif
    ini[1] = 1'b1; @(negedge clk); ini[1] = 1'b0; @(negedge clk);
    chk("restart_estado",   1, int'(estado[1]), 2);
    chk("restart_contagem", 1, contv(1), 0);
    chk("restart_rodada",   1, rodv(1), 0);

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
